// File: rtl/read_port_arbiter_if.sv
// Bundle of the per-channel read request lines and the shared memory read port.
// slave: arbiter view; master: the channels-plus-memory side that drives the arbiter.
interface read_port_arbiter_if #(
    parameter int NUM_CHANNELS      = 4,
    parameter int ADDRESS_BUS_WIDTH = 16
);
    logic [NUM_CHANNELS-1:0]                   ch_read_request;
    logic [NUM_CHANNELS*ADDRESS_BUS_WIDTH-1:0] ch_read_address;
    logic [15:0]                               ch_read_data;
    logic [NUM_CHANNELS-1:0]                   ch_read_finished_strobe;
    logic [ADDRESS_BUS_WIDTH-1:0]              mem_read_address;
    logic                                      mem_read_strobe;
    logic [15:0]                               mem_read_data;
    logic                                      mem_read_finished_strobe;

    modport slave (
        input  ch_read_request,
        input  ch_read_address,
        output ch_read_data,
        output ch_read_finished_strobe,
        output mem_read_address,
        output mem_read_strobe,
        input  mem_read_data,
        input  mem_read_finished_strobe
    );

    modport master (
        output ch_read_request,
        output ch_read_address,
        input  ch_read_data,
        input  ch_read_finished_strobe,
        input  mem_read_address,
        input  mem_read_strobe,
        output mem_read_data,
        output mem_read_finished_strobe
    );
endinterface

// File: rtl/read_port_arbiter.sv
// Round-robin share of one single-outstanding memory read port among NUM_CHANNELS requesters.
// Latency: strobe one cycle after grant, channel strobe one cycle after memory finish; per-read timeout.
module read_port_arbiter #(
    parameter int NUM_CHANNELS      = 4,
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    read_port_arbiter_if.slave   bus,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 timeout_strobe
);
    localparam int AW = ADDRESS_BUS_WIDTH;
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [2:0]              r_last_grant;
    logic [2:0]              r_grant;
    logic [7:0]              r_count;
    logic [15:0]             r_data;
    logic [NUM_CHANNELS-1:0] r_ch_strobe;
    logic [AW-1:0]           r_mem_addr;
    logic                    r_mem_strobe;
    logic                    r_busy;
    logic                    r_timeout;

    logic                    w_any;
    logic [2:0]              w_sel;
    logic [AW-1:0]           w_addr;
    logic [NUM_CHANNELS-1:0] w_onehot;

    // Two passes: first set bit strictly above last_grant, otherwise wrap to the lowest set bit.
    always_comb begin
        w_any = 1'b0;
        w_sel = 3'd0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!w_any && bus.ch_read_request[i] && (i > int'(r_last_grant))) begin
                w_any = 1'b1;
                w_sel = 3'(i);
            end
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!w_any && bus.ch_read_request[i]) begin
                w_any = 1'b1;
                w_sel = 3'(i);
            end
        end
    end

    always_comb begin
        w_addr = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_sel == 3'(i)) begin
                w_addr = bus.ch_read_address[i*AW +: AW];
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_onehot[i] = (r_grant == 3'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 3'(NUM_CHANNELS - 1);
            r_grant      <= 3'd0;
            r_count      <= 8'd0;
            r_data       <= 16'd0;
            r_ch_strobe  <= '0;
            r_mem_addr   <= '0;
            r_mem_strobe <= 1'b0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_any) begin
                        r_grant      <= w_sel;
                        r_last_grant <= w_sel;
                        r_mem_addr   <= w_addr;
                        r_mem_strobe <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mem_strobe <= 1'b0;
                    r_count      <= 8'd0;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    r_count <= r_count + 8'd1;
                    // A finish on the last allowed cycle still completes the read.
                    if (bus.mem_read_finished_strobe) begin
                        r_data      <= bus.mem_read_data;
                        r_ch_strobe <= w_onehot;
                        r_state     <= DONE;
                    end else if (r_count == LP_TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                DONE: begin
                    r_ch_strobe <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ch_read_data            = r_data;
    assign bus.ch_read_finished_strobe = r_ch_strobe;
    assign bus.mem_read_address        = r_mem_addr;
    assign bus.mem_read_strobe         = r_mem_strobe;
    assign grant_id                    = r_grant;
    assign busy                        = r_busy;
    assign timeout_strobe              = r_timeout;
endmodule

// File: tb/tb_read_port_arbiter.sv
// Scoreboarded bench: requester and memory models drive the arbiter, expected reads queue up front.
module tb_read_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int TO = 8;

    typedef struct {
        int          ch;
        logic [15:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] grant_id;
    logic       busy;
    logic       timeout_strobe;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_mem_cyc = 0;
    int          ch_cyc = 0;
    int          to_cyc = 0;
    int          n_to = 0;
    int          mem_lat = 1;
    logic        mem_never = 1'b0;
    int          rem[N];
    logic [AW-1:0] addr[N];
    exp_t        sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    read_port_arbiter_if #(.NUM_CHANNELS(N), .ADDRESS_BUS_WIDTH(AW)) bus ();

    read_port_arbiter #(
        .NUM_CHANNELS(N),
        .ADDRESS_BUS_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .grant_id(grant_id),
        .busy(busy),
        .timeout_strobe(timeout_strobe)
    );

    for (genvar g = 0; g < N; g++) begin : g_req
        assign bus.ch_read_request[g]          = (rem[g] != 0);
        assign bus.ch_read_address[g*AW +: AW] = addr[g];
    end

    function automatic logic [15:0] mem_fn(logic [15:0] a);
        return (a == 16'h0100) ? 16'hBEEF : ((a ^ 16'h5A00) + 16'h0003);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(int ch);
        exp_t e;
        e.ch   = ch;
        e.data = mem_fn(addr[ch]);
        sb.push_back(e);
    endtask

    task automatic drain(string tag, int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_mem_strobe(string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.mem_read_strobe && k < 20);
        check(tag, bus.mem_read_strobe, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        mem_never = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic stray_finish(logic [15:0] d);
        @(posedge clk);
        #1;
        bus.mem_read_finished_strobe = 1'b1;
        bus.mem_read_data            = d;
        @(posedge clk);
        #1;
        bus.mem_read_finished_strobe = 1'b0;
    endtask

    // Memory: answers each command after mem_lat cycles unless told to hang.
    initial begin
        logic [AW-1:0] a;
        bus.mem_read_finished_strobe = 1'b0;
        bus.mem_read_data            = 16'h0;
        forever begin
            @(negedge clk);
            if (bus.mem_read_strobe && !mem_never) begin
                a = bus.mem_read_address;
                repeat (mem_lat) @(posedge clk);
                #1;
                bus.mem_read_finished_strobe = 1'b1;
                bus.mem_read_data            = mem_fn(a);
                @(posedge clk);
                #1;
                bus.mem_read_finished_strobe = 1'b0;
            end
        end
    end

    // Requesters: each drops one pending read on the edge of its finish strobe.
    initial begin
        logic [N-1:0] fs;
        forever begin
            @(negedge clk);
            fs = bus.ch_read_finished_strobe;
            if (fs != '0) begin
                @(posedge clk);
                #1;
                for (int i = 0; i < N; i++) begin
                    if (fs[i] && rem[i] > 0) rem[i] = rem[i] - 1;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_read_strobe) last_mem_cyc = cyc;
            if (timeout_strobe) begin
                to_cyc = cyc;
                n_to++;
            end
            if (bus.ch_read_finished_strobe != '0) begin
                ch_cyc = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_ch_strobe", 32'(bus.ch_read_finished_strobe), 0);
                end else begin
                    e = sb.pop_front();
                    check("ch_strobe", 32'(bus.ch_read_finished_strobe), 32'(1) << e.ch);
                    check("ch_data", 32'(bus.ch_read_data), 32'(e.data));
                    check("grant_id", 32'(grant_id), 32'(e.ch));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int s_cyc;
        for (int i = 0; i < N; i++) begin
            rem[i]  = 0;
            addr[i] = '0;
        end

        // Reset state
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_mem", {bus.mem_read_strobe, bus.mem_read_address}, 0);
        check("rst_ch", {timeout_strobe, bus.ch_read_finished_strobe, bus.ch_read_data}, 0);

        // Single read, memory latency 2
        do_reset();
        mem_lat = 2;
        addr[0] = 16'h0100;
        push(0);
        rem[0] = 1;
        @(negedge clk);
        check("t1_strobe_c0", bus.mem_read_strobe, 0);
        @(negedge clk);
        check("t1_strobe_c1", bus.mem_read_strobe, 1);
        check("t1_addr", bus.mem_read_address, 32'h0100);
        check("t1_busy", busy, 1);
        drain("t1_drain", 20);
        check("t1_latency", ch_cyc - last_mem_cyc, 3);
        repeat (2) @(negedge clk);
        check("t1_busy_after", busy, 0);

        // All four requesting continuously, two reads each
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < N; i++) addr[i] = AW'((i + 1) * 16);
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push(i);
        for (int i = 0; i < N; i++) rem[i] = 2;
        drain("t2_drain", 100);
        repeat (3) @(negedge clk);
        check("t2_busy_after", busy, 0);

        // Hung memory on ch2, then ch3 must be next
        do_reset();
        mem_never = 1'b1;
        addr[2] = 16'h0200;
        addr[3] = 16'h0300;
        rem[2] = 1;
        wait_mem_strobe("t3_strobe");
        s_cyc = cyc;
        check("t3_grant", grant_id, 2);
        rem[3] = 1;
        push(3);
        push(2);
        begin
            int k = 0;
            while (!timeout_strobe && k < 30) begin
                @(negedge clk);
                k++;
            end
        end
        check("t3_to_seen", timeout_strobe, 1);
        check("t3_to_delay", cyc - s_cyc, 9);
        check("t3_busy", busy, 0);
        check("t3_no_ch", sb.size(), 2);
        mem_never = 1'b0;
        @(negedge clk);
        check("t3_to_pulse", timeout_strobe, 0);
        drain("t3_drain", 60);
        check("t3_to_count", n_to, 1);

        // Stray finish while idle
        repeat (2) @(negedge clk);
        stray_finish(16'h1234);
        repeat (2) @(negedge clk);
        check("t4_data_held", bus.ch_read_data, 32'(mem_fn(16'h0200)));
        check("t4_busy", busy, 0);

        // Reset pulse during WAIT
        do_reset();
        mem_never = 1'b1;
        addr[0] = 16'h0120;
        addr[1] = 16'h0110;
        rem[1] = 1;
        wait_mem_strobe("t5_strobe");
        @(negedge clk);
        check("t5_in_wait", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out", {grant_id, busy, timeout_strobe, bus.mem_read_strobe}, 0);
        check("t5_rst_bus", {bus.mem_read_address, bus.ch_read_data, 12'h0, bus.ch_read_finished_strobe}, 0);
        rem[1] = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray_finish(16'h7777);
        repeat (2) @(negedge clk);
        check("t5_data_after", bus.ch_read_data, 0);
        check("t5_busy_after", busy, 0);
        mem_never = 1'b0;
        push(0);
        push(1);
        rem[0] = 1;
        rem[1] = 1;
        drain("t5_drain", 40);

        // ch1 drops on its finish edge while ch3 keeps requesting
        do_reset();
        mem_lat = 1;
        addr[1] = 16'h0111;
        addr[3] = 16'h0333;
        push(1);
        push(3);
        push(3);
        rem[1] = 1;
        rem[3] = 2;
        drain("t6_drain", 60);
        repeat (6) @(negedge clk);
        check("t6_idle", busy, 0);
        check("t6_req_clear", bus.ch_read_request, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
